uart_result_tx: RTL and testbench

Transmit side of the FPGA host link. On a start pulse it reads NUM_BYTES result bytes from the accelerator's result BRAM, addresses 0 through NUM_BYTES-1. It serializes each byte onto the UART TX pin as 8N1 frames, LSB first, then pulses send_done. It pairs with the existing UART receive path that loads the 784-byte ifmap, and returns classification/ofmap results to the host at the same baud rate.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_serializer.sv | 126 ++++++++++++
 rtl/uart_result_tx.sv | 96 +++++++++
 tb/tb_uart_result_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the FPGA host link (TX and RX paths).
// UART_TX_PARITY_EN adds the S_PARITY serializer state for even-parity frames.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 868;
    localparam int unsigned UART_DATA_W       = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } ser_state_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        LOAD,
        SEND,
        DONE
    } ctrl_state_t;

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, 8 data bits LSB first, optional even parity
// (UART_TX_PARITY_EN), stop bit; every bit lasts CLKS_PER_BIT clocks.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tx_load,
    input  logic [UART_DATA_W-1:0] tx_byte,
    output logic                   tx_pin_out,
    output logic                   tx_active,
    output logic                   tx_frame_done
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    ser_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   pin_q, pin_d;
    logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif
    logic                   bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // The line level is registered from the current state, so the pin trails the
    // state by one clock; done_q is registered too and lines up with the pin's last stop cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        pin_d   = 1'b1;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_load) begin
                    state_d = S_START;
                    shift_d = tx_byte;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(tx_byte);
`endif
                end
            end
            S_START: begin
                pin_d = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                pin_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                pin_d = parity_q;
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                pin_d = 1'b1;
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            pin_q    <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            pin_q    <= pin_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_pin_out    = pin_q;
    assign tx_frame_done = done_q;
    assign tx_active     = (state_q != S_IDLE) || done_q;

endmodule

// File: rtl/uart_result_tx.sv
// Reads NUM_BYTES result bytes from BRAM (2-cycle latency) and sends them as UART
// frames, then pulses send_done. UART_TX_PARITY_EN selects 8E1 frames in the serializer.
module uart_result_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned NUM_BYTES    = 10,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic [ADDR_W-1:0]      result_read_addr,
    input  logic [UART_DATA_W-1:0] result_data_in,
    output logic                   tx_pin_out,
    output logic                   busy,
    output logic                   send_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tx_load;
    logic              tx_active;
    logic              tx_frame_done;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tx_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADDR;
                    addr_d  = '0;
                end
            end
            ADDR: state_d = WAIT;
            WAIT: state_d = LOAD;
            LOAD: begin
                // The serializer is always idle here; the guard only protects the shift register.
                if (!tx_active) begin
                    tx_load = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_frame_done) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                        addr_d  = '0;
                    end else begin
                        state_d = ADDR;
                        addr_d  = addr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign result_read_addr = addr_q;
    assign busy             = (state_q != IDLE) && (state_q != DONE);
    assign send_done        = (state_q == DONE);

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clock        (clock),
        .reset        (reset),
        .tx_load      (tx_load),
        .tx_byte      (result_data_in),
        .tx_pin_out   (tx_pin_out),
        .tx_active    (tx_active),
        .tx_frame_done(tx_frame_done)
    );

endmodule

// File: tb/tb_uart_result_tx.sv
// Self-checking bench for uart_result_tx: cycle-level model of line/busy/done/addr
// derived from frame arithmetic, plus a bit-level line decoder.
module tb_uart_result_tx;

    localparam int C  = 4;
    localparam int NB = 3;
    localparam int AW = 10;
`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int P     = F * C + 4;
    localparam int TOTAL = NB * P + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] addr;
    logic [7:0]    rdata;
    logic          pin;
    logic          busy;
    logic          done;

    always #5 clock = ~clock;

    uart_result_tx #(
        .CLKS_PER_BIT(C),
        .NUM_BYTES   (NB),
        .ADDR_W      (AW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .result_read_addr(addr),
        .result_data_in  (rdata),
        .tx_pin_out      (pin),
        .busy            (busy),
        .send_done       (done)
    );

    // Result BRAM with two-cycle read latency
    logic [7:0] mem [NB];
    logic [7:0] d1, d2;
    always @(posedge clock) begin
        d1 <= (addr < AW'(NB)) ? mem[addr] : 8'h00;
        d2 <= d1;
    end
    assign rdata = d2;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    bit          active   = 1'b0;
    bit          check_en = 1'b0;
    bit          mon_en   = 1'b0;
    int unsigned cyc      = 0;
    int unsigned t0_ref   = 0;
    logic [7:0]  snap [NB];
    logic [7:0]  exp_q [$];
    int          done_cnt = 0;
    logic        pin_log  [256];
    logic [AW-1:0] addr_log [256];
    logic        done_log [256];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int rel_now();
        return int'(cyc - t0_ref);
    endfunction

    function automatic logic exp_pin(input int r);
        int k, o, j;
        if (!active || r < 1 || r > NB * P) return 1'b1;
        k = (r - 1) / P;
        o = (r - 1) % P;
        if (o < 4) return 1'b1;
        j = (o - 4) / C;
        if (j == 0) return 1'b0;
        if (j <= 8) return snap[k][j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^snap[k];
`endif
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int r);
        return active && r >= 1 && r <= NB * P;
    endfunction

    function automatic logic exp_done(input int r);
        return active && r == TOTAL;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int r);
        if (!active || r < 1 || r > NB * P) return '0;
        return AW'((r - 1) / P);
    endfunction

    // Per-cycle compare against the model
    always @(negedge clock) begin
        int r;
        if (check_en) begin
            r = rel_now();
            chk("tx_pin_out", pin, exp_pin(r));
            chk("busy", busy, exp_busy(r));
            chk("send_done", done, exp_done(r));
            chk("result_read_addr", addr, exp_addr(r));
            if (done === 1'b1) done_cnt++;
            if (active && r >= 0 && r < 256) begin
                pin_log[r]  = pin;
                addr_log[r] = addr;
                done_log[r] = done;
            end
        end
    end

    // Bit-level line decoder
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en && pin === 1'b0) begin
                logic [7:0] b;
                b = '0;
                repeat (C / 2) @(negedge clock);
                chk("mon_start_bit", pin, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clock);
                    b[i] = pin;
                end
`ifdef UART_TX_PARITY_EN
                repeat (C) @(negedge clock);
                chk("mon_parity", pin, ^b);
`endif
                repeat (C) @(negedge clock);
                chk("mon_stop_bit", pin, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_extra_byte: got %0h expected none", b);
                end else begin
                    chk("mon_byte", b, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_transfer(input bit poke, input bit done_poke, input bit mon);
        for (int k = 0; k < NB; k++) begin
            snap[k] = mem[k];
            if (mon) exp_q.push_back(mem[k]);
        end
        mon_en   = mon;
        done_cnt = 0;
        start    = 1'b1;
        t0_ref   = cyc;
        active   = 1'b1;
        tick();
        start = 1'b0;
        while (rel_now() < TOTAL) begin
            start = poke && ($urandom_range(0, 7) == 0);
            tick();
        end
        start = done_poke;
        tick();
        start = 1'b0;
        chk("send_done_count", done_cnt, 1);
        if (mon) chk("bytes_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int k = 0; k < NB; k++) mem[k] = 8'h00;
        repeat (3) tick();
        check_en = 1'b1;
        start    = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("reset_pin", pin, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_addr", addr, 0);
        repeat (5) tick();

        // Hand-computed pins on the model/DUT for 0xA5 as first byte
        mem[0] = 8'hA5; mem[1] = 8'h01; mem[2] = 8'h80;
        run_transfer(1'b0, 1'b0, 1'b1);
        chk("lit_start_bit", pin_log[6], 0);
        chk("lit_a5_d0", pin_log[10], 1);
        chk("lit_a5_d1", pin_log[14], 0);
        chk("lit_a5_d2", pin_log[18], 1);
        chk("lit_a5_d3", pin_log[22], 0);
        chk("lit_a5_d4", pin_log[26], 0);
        chk("lit_a5_d5", pin_log[30], 1);
        chk("lit_a5_d6", pin_log[34], 0);
        chk("lit_a5_d7", pin_log[38], 1);
        chk("lit_pre_start", pin_log[4], 1);
        chk("lit_addr_byte1", addr_log[50], 1);
        chk("lit_addr_byte2", addr_log[100], 2);
`ifdef UART_TX_PARITY_EN
        chk("lit_done_cycle", done_log[145], 1);
        chk("lit_done_early", done_log[144], 0);
`else
        chk("lit_done_cycle", done_log[133], 1);
        chk("lit_done_early", done_log[132], 0);
`endif
        repeat (3) tick();

        // Extra start pulses mid-transfer and in the DONE cycle, then back-to-back
        mem[0] = 8'h01; mem[1] = 8'h80; mem[2] = 8'hFF;
        run_transfer(1'b1, 1'b1, 1'b1);
        tick();
        mem[0] = 8'h03; mem[1] = 8'h07; mem[2] = 8'h5A;
        run_transfer(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < NB; k++) mem[k] = 8'($urandom);
        run_transfer(1'b0, 1'b0, 1'b1);
        repeat (2) tick();

        // Reset in the middle of d[3] of byte 1
        for (int k = 0; k < NB; k++) mem[k] = 8'($urandom);
        for (int k = 0; k < NB; k++) snap[k] = mem[k];
        mon_en = 1'b0;
        start  = 1'b1;
        t0_ref = cyc;
        active = 1'b1;
        tick();
        start = 1'b0;
        while (rel_now() < P + 6 + 4 * C) tick();
        reset = 1'b1;
        tick();
        active = 1'b0;
        chk("midreset_pin", pin, 1);
        chk("midreset_busy", busy, 0);
        chk("midreset_addr", addr, 0);
        chk("midreset_done", done, 0);
        reset    = 1'b0;
        done_cnt = 0;
        repeat (2 * P) tick();
        chk("midreset_no_done", done_cnt, 0);
        for (int k = 0; k < NB; k++) mem[k] = 8'($urandom);
        run_transfer(1'b0, 1'b0, 1'b1);

        // Randomized transfers
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < NB; k++) mem[k] = 8'($urandom);
            run_transfer(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
